// File: rtl/tcnt_apb_slave_mem.sv
// APB3/APB4 completer backed by a word-addressed memory.
// Programmable wait states, PSLVERR on range/privilege faults, sticky protocol flag.
module tcnt_apb_slave_mem #(
  parameter int          PADDR_WIDTH  = 16,
  parameter int          PDATA_WIDTH  = 32,
  parameter int          DEPTH        = 64,
  parameter int          READ_DEFAULT = 0,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_1234
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [PADDR_WIDTH-1:0]   paddr,
  input  logic [PDATA_WIDTH-1:0]   pwdata,
  input  logic [PDATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]               pprot,
  input  logic [3:0]               cfg_wait_cycles,
  input  logic                     cfg_priv_only,
  output logic                     pready,
  output logic [PDATA_WIDTH-1:0]   prdata,
  output logic                     pslverr,
  output logic                     prot_err
);

  localparam int NB   = PDATA_WIDTH / 8;
  localparam int OFFS = $clog2(NB);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                 state_q;
  logic                   pready_q;
  logic [PDATA_WIDTH-1:0] prdata_q;
  logic                   pslverr_q;
  logic                   prot_err_q;
  logic [DEPTH-1:0]       vld_q;
  logic [PDATA_WIDTH-1:0] mem_q [DEPTH];
  logic [31:0]            lfsr_q;
  logic                   wr_q;
  logic [PADDR_WIDTH-1:0] addr_q;
  logic [PDATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]          strb_q;
  logic [AW-1:0]          widx_q;
  logic                   rnd_q;
  logic [3:0]             cnt_q;

  logic [31:0]            idx_d;
  logic [AW-1:0]          widx_d;
  logic                   err_d;
  logic                   rnd_d;
  logic [PDATA_WIDTH-1:0] rdata_d;
  logic [31:0]            lfsr_d;
  logic                   chg_d;
  logic                   unused_prot;

  assign unused_prot = ^pprot[2:1];

  assign idx_d  = 32'(paddr) >> OFFS;
  assign widx_d = idx_d[AW-1:0];
  assign err_d  = (idx_d >= 32'(DEPTH)) |
                  (cfg_priv_only & ~pprot[0]);

  // Galois LFSR, taps 32,22,2,1
  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^
                  (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

  assign chg_d = (pwrite != wr_q) | (paddr != addr_q) |
                 (pwdata != wdata_q) | (pstrb != strb_q);

  always_comb begin
    rdata_d = '0;
    rnd_d   = 1'b0;
    if (!err_d) begin
      if (vld_q[widx_d]) begin
        rdata_d = mem_q[widx_d];
      end else if (READ_DEFAULT == 1) begin
        rdata_d = lfsr_q[PDATA_WIDTH-1:0];
        rnd_d   = ~pwrite;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q    <= IDLE;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      prot_err_q <= 1'b0;
      vld_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      widx_q     <= '0;
      rnd_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            wr_q      <= pwrite;
            addr_q    <= paddr;
            wdata_q   <= pwdata;
            strb_q    <= pstrb;
            widx_q    <= widx_d;
            rnd_q     <= rnd_d;
            cnt_q     <= cfg_wait_cycles;
            pready_q  <= (cfg_wait_cycles == 4'd0);
            pslverr_q <= err_d;
            prdata_q  <= rdata_d;
            state_q   <= ACCESS;
          end else if (psel && penable) begin
            prot_err_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (!psel) begin
            prot_err_q <= 1'b1;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            state_q    <= IDLE;
          end else if (!pready_q) begin
            cnt_q    <= cnt_q - 4'd1;
            pready_q <= (cnt_q == 4'd1);
            if (chg_d) prot_err_q <= 1'b1;
          end else begin
            if (wr_q && !pslverr_q) begin
              for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) mem_q[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
              end
              vld_q[widx_q] <= 1'b1;
            end
            if (rnd_q) lfsr_q <= lfsr_d;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pready   = pready_q;
  assign prdata   = prdata_q;
  assign pslverr  = pslverr_q & pready_q;
  assign prot_err = prot_err_q;

endmodule

// File: tb/tb_tcnt_apb_slave_mem.sv
// Bench for tcnt_apb_slave_mem: zero-default and random-default instances
// share one bus and are checked against a word-level memory model.
module tb_tcnt_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [3:0]  cfg_wait_cycles;
  logic        cfg_priv_only;

  logic        pready0, pslverr0, prot_err0;
  logic [31:0] prdata0;
  logic        pready1, pslverr1, prot_err1;
  logic [31:0] prdata1;

  tcnt_apb_slave_mem #(.READ_DEFAULT(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .cfg_wait_cycles(cfg_wait_cycles),
    .cfg_priv_only(cfg_priv_only), .pready(pready0), .prdata(prdata0),
    .pslverr(pslverr0), .prot_err(prot_err0)
  );

  tcnt_apb_slave_mem #(.READ_DEFAULT(1)) dut1 (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .cfg_wait_cycles(cfg_wait_cycles),
    .cfg_priv_only(cfg_priv_only), .pready(pready1), .prdata(prdata1),
    .pslverr(pslverr1), .prot_err(prot_err1)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference model: 64 words, valid bits, and the random-default sequence
  logic [31:0] m_mem [64];
  bit          m_vld [64];
  logic [31:0] m_lfsr;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
    m_lfsr = 32'hACE1_1234;
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst pready", {31'b0, pready0}, 32'd0);
    chk("rst prdata", prdata0, 32'd0);
    chk("rst pslverr", {31'b0, pslverr0}, 32'd0);
    chk("rst prot_err", {31'b0, prot_err0}, 32'd0);
    chk("rst prot_err1", {31'b0, prot_err1}, 32'd0);
    presetn = 1'b1;
    m_reset();
    @(posedge pclk);
    #1;
  endtask

  task automatic xfer(input bit wr, input logic [15:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input logic [2:0] prot, input logic [3:0] ws,
                      input bit po, input string nm,
                      output logic [31:0] rd0, output logic [31:0] rd1,
                      output bit err_o);
    int idx;
    bit err;
    int acc;
    logic [31:0] e0, e1;
    idx = int'(addr >> 2);
    err = (idx >= 64) || (po && !prot[0]);
    if (err) begin
      e0 = 0; e1 = 0;
    end else if (m_vld[idx]) begin
      e0 = m_mem[idx]; e1 = m_mem[idx];
    end else begin
      e0 = 0; e1 = m_lfsr;
    end
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = data; pstrb = strb; pprot = prot;
    cfg_wait_cycles = ws; cfg_priv_only = po;
    @(posedge pclk);
    #1 penable = 1'b1;
    acc = 0;
    do begin
      acc++;
      @(negedge pclk);
    end while (!pready0 && acc < 40);
    chk({nm, " latency"}, 32'(acc), 32'(ws) + 32'd1);
    chk({nm, " pready1"}, {31'b0, pready1}, 32'd1);
    chk({nm, " pslverr0"}, {31'b0, pslverr0}, {31'b0, err});
    chk({nm, " pslverr1"}, {31'b0, pslverr1}, {31'b0, err});
    if (!wr) begin
      chk({nm, " prdata0"}, prdata0, e0);
      chk({nm, " prdata1"}, prdata1, e1);
    end
    rd0 = prdata0;
    rd1 = prdata1;
    err_o = pslverr0;
    @(posedge pclk);
    #1 psel = 1'b0;
    penable = 1'b0;
    if (wr && !err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_mem[idx][8*b +: 8] = data[8*b +: 8];
      m_vld[idx] = 1'b1;
    end
    if (!wr && !err && !m_vld[idx]) m_lfsr = lfsr_next(m_lfsr);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [3:0]  ws;
    bit          po;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] r0, r1, ra, rb;
    bit e;
    int acc;

    tbl[0]  = '{1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b001, 4'd0, 0, 32'h0, 0};
    tbl[1]  = '{0, 16'h0010, 32'h0, 4'hF, 3'b001, 4'd0, 0, 32'hDEADBEEF, 0};
    tbl[2]  = '{1, 16'h0004, 32'h12345678, 4'hF, 3'b001, 4'd3, 0, 32'h0, 0};
    tbl[3]  = '{0, 16'h0004, 32'h0, 4'hF, 3'b001, 4'd1, 0, 32'h12345678, 0};
    tbl[4]  = '{1, 16'h0008, 32'h11223344, 4'hF, 3'b001, 4'd0, 0, 32'h0, 0};
    tbl[5]  = '{1, 16'h0008, 32'hAABBCCDD, 4'h5, 3'b001, 4'd2, 0, 32'h0, 0};
    tbl[6]  = '{0, 16'h0008, 32'h0, 4'hF, 3'b001, 4'd0, 0, 32'h11BB33DD, 0};
    tbl[7]  = '{1, 16'h0100, 32'hCAFEF00D, 4'hF, 3'b001, 4'd0, 0, 32'h0, 1};
    tbl[8]  = '{0, 16'h0100, 32'h0, 4'hF, 3'b001, 4'd1, 0, 32'h0, 1};
    tbl[9]  = '{0, 16'h0013, 32'h0, 4'hF, 3'b001, 4'd0, 0, 32'hDEADBEEF, 0};
    tbl[10] = '{0, 16'h0010, 32'h0, 4'hF, 3'b000, 4'd0, 1, 32'h0, 1};
    tbl[11] = '{0, 16'h0010, 32'h0, 4'hF, 3'b001, 4'd0, 1, 32'hDEADBEEF, 0};
    tbl[12] = '{1, 16'h0010, 32'h0, 4'hF, 3'b000, 4'd2, 1, 32'h0, 1};
    tbl[13] = '{0, 16'h0010, 32'h0, 4'hF, 3'b000, 4'd0, 0, 32'hDEADBEEF, 0};
    tbl[14] = '{1, 16'h000C, 32'h01020304, 4'hF, 3'b001, 4'd0, 0, 32'h0, 0};
    tbl[15] = '{1, 16'h000C, 32'hFFFFFFFF, 4'h0, 3'b001, 4'd1, 0, 32'h0, 0};
    tbl[16] = '{0, 16'h000C, 32'h0, 4'hF, 3'b001, 4'd0, 0, 32'h01020304, 0};

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    cfg_wait_cycles = '0; cfg_priv_only = 1'b0;
    m_reset();
    do_reset();

    // random default: first two reads of an unwritten word
    xfer(0, 16'h0020, 0, 4'hF, 3'b001, 4'd0, 0, "dflt0", r0, ra, e);
    xfer(0, 16'h0020, 0, 4'hF, 3'b001, 4'd0, 0, "dflt1", r0, rb, e);
    chk("lfsr first", ra, 32'hACE11234);
    chk("lfsr second", rb, 32'h5670891A);
    chk("zero default", r0, 32'h0);

    foreach (tbl[i]) begin
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].prot,
           tbl[i].ws, tbl[i].po, $sformatf("tbl%0d", i), r0, r1, e);
      chk($sformatf("tbl%0d err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
      if (!tbl[i].wr)
        chk($sformatf("tbl%0d rd", i), r0, tbl[i].exp_rd);
    end
    chk("no prot_err yet", {31'b0, prot_err0}, 32'd0);

    // paddr changes during a wait state
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0010;
    pprot = 3'b001; cfg_wait_cycles = 4'd3; cfg_priv_only = 1'b0;
    @(posedge pclk);
    #1 penable = 1'b1;
    paddr = 16'h0014;
    @(posedge pclk);
    #1 paddr = 16'h0010;
    acc = 0;
    do begin
      acc++;
      @(negedge pclk);
    end while (!pready0 && acc < 40);
    chk("chg pready", {31'b0, pready0}, 32'd1);
    chk("chg prot_err", {31'b0, prot_err0}, 32'd1);
    @(posedge pclk);
    #1 psel = 1'b0;
    penable = 1'b0;
    xfer(0, 16'h0010, 0, 4'hF, 3'b001, 4'd0, 0, "after chg", r0, r1, e);
    chk("prot_err sticky", {31'b0, prot_err0}, 32'd1);

    // psel dropped mid-access aborts the write
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0018;
    pwdata = 32'hAAAA5555; pstrb = 4'hF; cfg_wait_cycles = 4'd3;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(posedge pclk);
    #1 psel = 1'b0;
    penable = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("abort pready", {31'b0, pready0}, 32'd0);
    chk("abort prot_err1", {31'b0, prot_err1}, 32'd1);
    @(posedge pclk);
    #1;
    xfer(0, 16'h0018, 0, 4'hF, 3'b001, 4'd0, 0, "abort rd", r0, r1, e);

    // reset in the middle of a write
    do_reset();
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    @(posedge pclk);
    #1 psel = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    chk("idle penable prot_err", {31'b0, prot_err0}, 32'd1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0030;
    pwdata = 32'h12121212; pstrb = 4'hF; cfg_wait_cycles = 4'd2;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(posedge pclk);
    #1 presetn = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
    @(posedge pclk);
    @(negedge pclk);
    chk("mid rst pready", {31'b0, pready0}, 32'd0);
    chk("mid rst prdata", prdata0, 32'd0);
    chk("mid rst pslverr", {31'b0, pslverr0}, 32'd0);
    chk("mid rst prot_err", {31'b0, prot_err0}, 32'd0);
    presetn = 1'b1;
    m_reset();
    @(posedge pclk);
    #1;
    xfer(0, 16'h0030, 0, 4'hF, 3'b001, 4'd1, 0, "post rst", r0, r1, e);
    chk("post rst seed", r1, 32'hACE11234);
    xfer(0, 16'h0010, 0, 4'hF, 3'b001, 4'd0, 0, "valid cleared", r0, r1, e);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      logic [3:0]  s;
      int idx;
      if ($urandom_range(0, 9) == 0) begin
        a = 16'($urandom);
      end else begin
        idx = $urandom_range(0, 71);
        a = {idx[13:0], 2'($urandom)};
      end
      idx = int'(a >> 2);
      s = 4'($urandom);
      if (idx < 64 && !m_vld[idx]) s = 4'hF;
      xfer(1'($urandom), a, $urandom, s, 3'($urandom),
           4'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
           $sformatf("rnd%0d", n), r0, r1, e);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge pclk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcnt_apb_slave_mem.md
Name: tcnt_apb_slave_mem

Overview:
APB3/APB4 completer model that consumes transactions driven by the tcnt APB master agent, standing directly downstream of it on the bus. It backs a word-addressed memory and inserts programmable wait states. It flags PSLVERR for out-of-range or privilege-violating accesses and returns a configurable default value (zero or pseudo-random) for never-written locations. It also records sticky APB protocol violations for the scoreboard.

Parameters:
PADDR_WIDTH, 16, address width in bits (1..32).
PDATA_WIDTH, 32, data width in bits (8, 16 or 32).
DEPTH, 64, number of data words implemented (power of two, ≤ 2^(PADDR_WIDTH-log2(PDATA_WIDTH/8))).
READ_DEFAULT, 0, value returned for unwritten words: 0 = ZERO, 1 = RANDOM.
LFSR_SEED, 32'hACE1_1234, non-zero reset seed for the random-default generator.

Ports:
pclk  in  1  bus clock; all logic on the rising edge.
presetn  in  1  synchronous, active-low reset.
psel  in  1  slave select.
penable  in  1  access phase indicator.
pwrite  in  1  1 = WRITE, 0 = READ.
paddr  in  PADDR_WIDTH  byte address.
pwdata  in  PDATA_WIDTH  write data.
pstrb  in  PDATA_WIDTH/8  byte write strobes.
pprot  in  3  [0] 1 = PRIVILEGED, [1] 1 = NON_SECURE, [2] 1 = INSTRUCTION.
cfg_wait_cycles  in  4  number of wait states inserted per transfer, sampled in the setup cycle.
cfg_priv_only  in  1  when 1, a NORMAL access (pprot[0]=0) is rejected.
pready  out  1  transfer completion.
prdata  out  PDATA_WIDTH  read data, valid while pready=1 and the transfer is a read.
pslverr  out  1  error response, valid while pready=1.
prot_err  out  1  sticky protocol-violation flag; cleared only by reset.

Behaviour:
- Reset (presetn=0 at a rising edge): state=IDLE; pready=0; prdata=0; pslverr=0; prot_err=0; written-valid bits all cleared; LFSR=LFSR_SEED. Memory contents are don't-care.
- Word index = paddr >> log2(PDATA_WIDTH/8). Low byte-offset bits are ignored. Index ≥ DEPTH is out of range.
- FSM states: IDLE and ACCESS.
- IDLE:
  - psel=1, penable=0 is a setup cycle. Capture pwrite, index, pwdata, pstrb, pprot. Load cnt=cfg_wait_cycles. Set pready<=(cfg_wait_cycles==0). Go to ACCESS.
  - psel=1, penable=1 sets prot_err=1; state stays IDLE.
- Error decision at setup: err = out_of_range OR (cfg_priv_only AND pprot[0]==0). pslverr is driven to err and qualified by pready.
- Read data is computed at setup and registered:
  - err: 0.
  - Word written since reset: the stored word.
  - Otherwise: 0 if READ_DEFAULT=0, or the current LFSR value if READ_DEFAULT=1.
- ACCESS with pready=0:
  - Decrement cnt; pready<=(cnt==1).
  - If psel, pwrite, paddr, pwdata or pstrb differs from the captured value, set prot_err=1.
- ACCESS with pready=1 (completion edge):
  - Write with !err: each byte lane i with pstrb[i]=1 is updated; the word's valid bit is set. pstrb=0 sets the valid bit but changes no data.
  - Write with err: no memory change.
  - Then pready<=0, pslverr<=0, state<=IDLE.
  - prdata is held until the next setup; it is ignored by masters.
- Latency: N wait states give pready=1 in access cycle N+1, i.e. N+2 cycles from setup to completion.
- LFSR: 32-bit Galois, taps 32,22,2,1. Advances once per completed read that returned a random default. Bits [PDATA_WIDTH-1:0] are used.
- Back-to-back transfers: a setup immediately after completion is accepted in IDLE. No idle cycle is required.
- psel deasserted mid-ACCESS: set prot_err=1 and abort to IDLE with no memory write.
- Reset mid-transfer: the transfer is abandoned, no write is committed, and all outputs return to reset values.

Test Plan:
- Write 0xDEADBEEF to 0x0010 (pstrb=4'hF, wait=0), then read 0x0010 → each completes in 2 cycles; read prdata=0xDEADBEEF, pslverr=0.
- READ_DEFAULT=0, read unwritten 0x0020 → prdata=0. READ_DEFAULT=1, read 0x0020 twice → two distinct values, both equal to the first two LFSR outputs from LFSR_SEED.
- cfg_wait_cycles=3, write 0x0004 → pready low for 3 access cycles, high on the 4th; total 5 cycles from setup.
- Write 0x11223344 to 0x0008, then write 0xAABBCCDD with pstrb=4'b0101 → read returns 0x11BB33DD.
- Access index 64 (paddr=0x0100, DEPTH=64) → pslverr=1, prdata=0, memory unchanged. Set cfg_priv_only=1 and read with pprot=3'b000 → pslverr=1.
- Change paddr during a wait state → prot_err=1 and stays 1. Assert presetn=0 during ACCESS of a write → no commit, later read returns the default, prot_err=0.
